// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Multiplexed common-anode seven-segment driver. It scans DIGITS hex digits
// one at a time, with one digit slot lasting REFRESH_DIV clock cycles.
// New digit values arrive through a load/ready handshake. They sit in a
// pending register and move to the display register only at a frame
// boundary, so a single scan never shows a mix of old and new digits.
// Optional feature macro: SEG7_LZ_BLANK_EN turns on leading-zero
// suppression, which is computed from the display register.
module seg7_scan_driver #(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] data,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic [DIGITS-1:0]   en_mask,
  input  logic                load,
  output logic                ready,
  output logic [6:0]          hex,
  output logic                DP,
  output logic [DIGITS-1:0]   AN
);

  localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF  = 7'h7F;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_q, pend_d, disp_q, disp_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic                ready_q, ready_d;
  logic [6:0]          hex_q, hex_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [DIGITS-1:0]   blank;

  // Active-low segment patterns, with hex[0]=a through hex[6]=g.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Per-digit blanking mask. A digit with a lit decimal point counts as
  // significant, so it also keeps every digit below it visible.
`ifdef SEG7_LZ_BLANK_EN
  always_comb begin
    logic lz;
    // NOTE: every variable gets a default before any conditional write so always_comb cannot infer a latch.
    lz    = 1'b1;
    blank = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz       = lz & (disp_q[4*i +: 4] == 4'd0) & ~disp_dp_q[i];
      blank[i] = lz & (i != 0);
    end
  end
`else
  assign blank = '0;
`endif

  // Next-state logic for the prescaler, the scan index, the handshake and the registered pin drive.
  always_comb begin
    logic       tick;
    logic       wrap_tick;
    logic       show;
    logic [3:0] nib;

    cnt_d     = cnt_q;
    idx_d     = idx_q;
    pend_d    = pend_q;
    pend_dp_d = pend_dp_q;
    disp_d    = disp_q;
    disp_dp_d = disp_dp_q;
    ready_d   = ready_q;

    tick      = (cnt_q == CNT_LAST);
    wrap_tick = tick && (idx_q == IDX_LAST);

    cnt_d = tick ? '0 : cnt_q + 1'b1;
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    // ready_q selects which branch can run. A load accepted on a wrap_tick
    // therefore goes to pending only and is committed one frame later.
    if (load && ready_q) begin
      pend_d    = data;
      pend_dp_d = dp_in;
      ready_d   = 1'b0;
    end else if (wrap_tick && !ready_q) begin
      disp_d    = pend_q;
      disp_dp_d = pend_dp_q;
      ready_d   = 1'b1;
    end

    nib  = disp_q[{idx_q, 2'b00} +: 4];
    show = en_mask[idx_q] && !blank[idx_q];
    an_d  = show ? ~(DIGITS'(1) << idx_q) : '1;
    hex_d = show ? seg_decode(nib) : SEG_OFF;
    dp_d  = show ? ~disp_dp_q[idx_q] : 1'b1;
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      // NOTE: pending and display registers are explicitly reset so that a reset discards any queued value.
      pend_q    <= '0;
      pend_dp_q <= '0;
      disp_q    <= '0;
      disp_dp_q <= '0;
      ready_q   <= 1'b1;
      hex_q     <= SEG_OFF;
      dp_q      <= 1'b1;
      an_q      <= '1;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      pend_dp_q <= pend_dp_d;
      disp_q    <= disp_d;
      disp_dp_q <= disp_dp_d;
      ready_q   <= ready_d;
      hex_q     <= hex_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
    end
  end

  assign ready = ready_q;
  assign hex   = hex_q;
  assign DP    = dp_q;
  assign AN    = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver with DIGITS=4 and REFRESH_DIV=4.
// A frame-level reference model is compared against the DUT on every cycle.
// Directed scenarios use fixed expected values, and the scan table is
// driven from a small array of records.
module tb_seg7_scan_driver;

  localparam int D   = 4;
  localparam int RD  = 4;
  localparam int FRM = D * RD;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   data;
  logic [3:0]    dp_in;
  logic [3:0]    en_mask;
  logic          load;
  logic          ready;
  logic [6:0]    hex;
  logic          DP;
  logic [3:0]    AN;

  seg7_scan_driver #(.DIGITS(D), .REFRESH_DIV(RD), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .data(data), .dp_in(dp_in), .en_mask(en_mask),
    .load(load), .ready(ready), .hex(hex), .DP(DP), .AN(AN)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model. It tracks frame position by counting edges since reset release.
  logic [6:0]  seg_tab [16];
  logic [15:0] m_pend, m_disp;
  logic [3:0]  m_pdp, m_ddp;
  logic        m_ready;
  int          t;
  logic [3:0]  e_an;
  logic [6:0]  e_hex;
  logic        e_dp;

  task automatic model_edge();
    int  idx;
    bit  blanked, show;
    if (rst) begin
      m_pend = '0; m_disp = '0; m_pdp = '0; m_ddp = '0; m_ready = 1'b1; t = 0;
      e_an = 4'hF; e_hex = 7'h7F; e_dp = 1'b1;
    end else begin
      t++;
      idx = ((t - 1) / RD) % D;
`ifdef SEG7_LZ_BLANK_EN
      blanked = (idx != 0) && ((m_disp >> (4 * idx)) == 0) && ((m_ddp >> idx) == 0);
`else
      blanked = 1'b0;
`endif
      show  = en_mask[idx] && !blanked;
      e_an  = show ? ~(4'b0001 << idx) : 4'hF;
      e_hex = show ? seg_tab[(m_disp >> (4 * idx)) & 16'hF] : 7'h7F;
      e_dp  = show ? ~m_ddp[idx] : 1'b1;
      if (load && m_ready) begin
        m_pend = data; m_pdp = dp_in; m_ready = 1'b0;
      end else if ((t % FRM) == 0 && !m_ready) begin
        m_disp = m_pend; m_ddp = m_pdp; m_ready = 1'b1;
      end
    end
  endtask

  // Runs one clock edge and compares all outputs with the model.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("cycle", {19'd0, ready, AN, hex, DP}, {19'd0, m_ready, e_an, e_hex, e_dp});
  endtask

  task automatic wait_frame();
    repeat ((FRM - (t % FRM)) % FRM) step();
  endtask

  function automatic int slot();
    return ((t - 1) / RD) % D;
  endfunction

  typedef struct {
    logic [3:0] en;
    logic [3:0] an;
    logic [6:0] hex;
    logic       dp;
  } vec_t;

  vec_t       vecs [8];
  logic [6:0] exp_abcd [4];
  logic [3:0] lz_an [4];
  logic [6:0] lz_hex [4];
  logic [3:0] an_norm [4];

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    // Display 3210, dp 0100. The first frame has all digits enabled and the
    // second frame uses en_mask 0101.
    vecs[0] = '{4'hF, 4'hE, 7'h40, 1'b1};
    vecs[1] = '{4'hF, 4'hD, 7'h79, 1'b1};
    vecs[2] = '{4'hF, 4'hB, 7'h24, 1'b0};
    vecs[3] = '{4'hF, 4'h7, 7'h30, 1'b1};
    vecs[4] = '{4'h5, 4'hE, 7'h40, 1'b1};
    vecs[5] = '{4'h5, 4'hF, 7'h7F, 1'b1};
    vecs[6] = '{4'h5, 4'hB, 7'h24, 1'b0};
    vecs[7] = '{4'h5, 4'hF, 7'h7F, 1'b1};
    exp_abcd = '{7'h21, 7'h46, 7'h03, 7'h08};
    an_norm  = '{4'hE, 4'hD, 4'hB, 4'h7};
`ifdef SEG7_LZ_BLANK_EN
    lz_an  = '{4'hE, 4'hD, 4'hF, 4'hF};
    lz_hex = '{7'h40, 7'h12, 7'h7F, 7'h7F};
`else
    lz_an  = '{4'hE, 4'hD, 4'hB, 4'h7};
    lz_hex = '{7'h40, 7'h12, 7'h40, 7'h40};
`endif

    rst = 1'b1; load = 1'b0; data = '0; dp_in = '0; en_mask = 4'hF;

    // Reset is held for three cycles.
    repeat (3) begin
      step();
      check("rst_an", {28'd0, AN}, 32'hF);
      check("rst_hex", {25'd0, hex}, 32'h7F);
      check("rst_dp_ready", {30'd0, DP, ready}, 32'h3);
    end
    rst = 1'b0;
    step();
    check("release_an", {28'd0, AN}, 32'hE);
    check("release_hex", {25'd0, hex}, 32'h40);

    // Scan order and enable mask.
    load = 1'b1; data = 16'h3210; dp_in = 4'b0100;
    step();
    load = 1'b0;
    wait_frame();
    for (int k = 0; k < 8; k++) begin
      en_mask = vecs[k].en;
      repeat (RD) begin
        step();
        check("scan_an", {28'd0, AN}, {28'd0, vecs[k].an});
        check("scan_hex", {25'd0, hex}, {25'd0, vecs[k].hex});
        check("scan_dp", {31'd0, DP}, {31'd0, vecs[k].dp});
      end
    end
    en_mask = 4'hF;

    // Handshake. The second load, made while ready is low, is dropped.
    repeat (2) step();
    load = 1'b1; data = 16'hABCD; dp_in = 4'b0000;
    step();
    check("hs_ready_drop", {31'd0, ready}, 32'd0);
    data = 16'h1111;
    step();
    check("hs_ready_held", {31'd0, ready}, 32'd0);
    load = 1'b0;
    wait_frame();
    check("hs_ready_back", {31'd0, ready}, 32'd1);
    repeat (FRM) begin
      step();
      check("hs_hex", {25'd0, hex}, {25'd0, exp_abcd[slot()]});
    end

    // Load accepted on the same cycle as wrap_tick.
    repeat (FRM - 1) step();
    load = 1'b1; data = 16'h5555;
    step();
    load = 1'b0;
    check("coinc_captured", {31'd0, ready}, 32'd0);
    repeat (FRM) begin
      step();
      check("coinc_old", {25'd0, hex}, {25'd0, exp_abcd[slot()]});
    end
    repeat (FRM) begin
      step();
      check("coinc_new", {25'd0, hex}, 32'h12);
    end

    // Reset while a load is pending.
    load = 1'b1; data = 16'h9999;
    step();
    load = 1'b0;
    check("midrst_pending", {31'd0, ready}, 32'd0);
    rst = 1'b1;
    step();
    check("midrst_ready", {31'd0, ready}, 32'd1);
    check("midrst_an", {28'd0, AN}, 32'hF);
    rst = 1'b0;
    step();
    check("midrst_disp0", {25'd0, hex}, 32'h40);
    step();
    check("midrst_discard", {31'd0, ready}, 32'd1);

    // Leading zeros, first with no decimal points and then with dp on digit 3.
    load = 1'b1; data = 16'h0050; dp_in = 4'b0000;
    step();
    load = 1'b0;
    wait_frame();
    repeat (FRM) begin
      step();
      check("lz_an", {28'd0, AN}, {28'd0, lz_an[slot()]});
      check("lz_hex", {25'd0, hex}, {25'd0, lz_hex[slot()]});
    end
    load = 1'b1; dp_in = 4'b1000;
    step();
    load = 1'b0;
    wait_frame();
    repeat (FRM) begin
      step();
      check("lzdp_an", {28'd0, AN}, {28'd0, an_norm[slot()]});
      check("lzdp_hex", {25'd0, hex}, (slot() == 1) ? 32'h12 : 32'h40);
    end

    // Random stimulus. The model checks every cycle.
    for (int n = 0; n < 600; n++) begin
      rst   = ($urandom_range(63) == 0);
      load  = ($urandom_range(3) == 0);
      data  = 16'($urandom);
      dp_in = 4'($urandom);
      if ($urandom_range(7) == 0) en_mask = ($urandom_range(1) == 0) ? 4'hF : 4'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised multiplexed seven-segment driver, successor to the single-digit static display path. Scans DIGITS hex digits across common-anode displays, one digit at a time, at a programmable refresh rate. Shows per-digit decimal points and per-digit enables. New values are accepted through a load/ready handshake and committed only at frame boundaries, so a scan never mixes old and new digits. Sits between the board top (SW/BTN logic) and the hex/DP/AN pins.

Parameters:
DIGITS, 8, number of digits scanned; legal range 1..8.
REFRESH_DIV, 100000, clk cycles per digit slot; legal minimum 2. At 100 MHz the default gives 1 kHz per digit.
CNT_W, 17, prescaler counter width; must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
data  input  4*DIGITS  digit nibbles; digit i = data[4i+3:4i]; digit 0 is rightmost
dp_in  input  DIGITS  decimal point per digit, 1 = lit
en_mask  input  DIGITS  digit enable, 1 = shown; sampled live, not via handshake
load  input  1  request to capture data/dp_in
ready  output  1  high when a load will be accepted
hex  output  7  segments active-low; hex[0]=a ... hex[6]=g
DP  output  1  decimal point, active-low
AN  output  DIGITS  anode selects, active-low, one-hot-low or all high

Behaviour:
- Reset: prescaler=0, idx=0, pending and display registers=0, ready=1, hex=7'h7F, DP=1, AN=all ones.
- Prescaler counts 0..REFRESH_DIV-1 and wraps. tick = (count==REFRESH_DIV-1).
- On tick, idx advances by one and wraps from DIGITS-1 to 0. wrap_tick = tick && idx==DIGITS-1. With DIGITS=1, every tick is a wrap_tick.
- Outputs are registered and updated every cycle from the current idx, so latency is 1 cycle from idx to pins.
- AN[idx]=0 when en_mask[idx]=1. All other AN bits are 1.
- If en_mask[idx]=0: AN all ones, hex=7'h7F, DP=1.
- hex = active-low decode of display nibble idx: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex values).
- DP = ~display_dp[idx].
- Handshake:
  - load && ready: pending<=data/dp_in and ready<=0 on the next edge.
  - load && !ready: the request is ignored and dropped; the master must hold or retry.
  - wrap_tick && !ready: display<=pending and ready<=1.
  - load accepted on the same cycle as wrap_tick (ready was 1): the capture goes to pending only. It commits at the following wrap_tick.
  - Maximum load-to-display latency is DIGITS*REFRESH_DIV+1 cycles.
- rst mid-scan or with a pending load: everything returns to reset values and pending data is discarded.
- en_mask changes take effect on the next cycle, without waiting for a frame boundary.

Optional Feature:
SEG7_LZ_BLANK_EN.
- Defined: leading-zero suppression. Digit i is blanked (AN bit high, hex=7'h7F) when its display nibble is 0 and every higher-index digit is also 0. Digit 0 is never suppressed. A digit whose dp bit is 1 is never suppressed. Suppression is computed from the display register, not pending.
- Undefined: all enabled digits are shown, including leading zeros.

Test Plan:
All scenarios use DIGITS=4, REFRESH_DIV=4.
- Reset release: hold rst 3 cycles, release. During rst, AN=4'hF, hex=7F, DP=1, ready=1. The first cycle after release shows AN=4'hE (digit 0), hex=40.
- Scan order: load data=16'h3210 with dp_in=4'b0100, then wait one frame. AN steps E,D,B,7 for 4 cycles each and repeats. hex steps 40,79,24,30. DP is low only while AN=B.
- Handshake: assert load with data=16'hABCD. ready drops next cycle. A second load with 16'h1111 while ready=0 is ignored. At the next wrap_tick the display becomes ABCD, hex sequence 21,46,03,08, and ready=1.
- Coincident load and wrap_tick: load 16'h5555 exactly on a wrap_tick. The display keeps old data for one more frame, then shows 12 on all digits.
- Enable mask and reset mid-op: en_mask=4'b0101 gives AN=E, then F, then B, then F. Asserting rst while ready=0 gives ready=1, display 0000 and AN=F.
- With SEG7_LZ_BLANK_EN: data=16'h0050, dp=0 gives digit 0 hex=40, digit 1 hex=12, digits 2 and 3 with AN=F. With dp_in=4'b1000, all digits are shown.
